// File: rtl/even_parity_pkg.sv
// Shared definitions for the even-parity serial link (transmitter and receiver).
//   tx_state_e      : frame sequencer states
//   LINE_IDLE       : serial line level when no frame is in progress (mark)
//   START_BIT       : serial line level of the start bit (space)
//   cnt_width()     : counter width helper, never narrower than one bit
package even_parity_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

  // $clog2(1) is 0, which would give a zero-width counter.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/even_parity_gen.sv
// Even parity generator: single-bit XOR over all DATA_W data bits.
// Appending the result to the data makes the total count of ones even.
// Shared with the receive side of the link.
//   data_i    input  [DATA_W-1:0]  data word
//   parity_o  output               even parity bit (0 for all-zero data)
module even_parity_gen #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] data_i,
  output logic              parity_o
);

  assign parity_o = ^data_i;

endmodule

// File: rtl/even_parity_tx.sv
// Even-parity serial transmitter.
// Takes a byte on a valid/ready handshake and sends
// start bit, data LSB-first, even parity bit, STOP_BITS stop bits,
// each bit held for CLKS_PER_BIT clocks.
//   clk         input               rising-edge clock
//   rst_n       input               asynchronous active-low reset
//   in_data     input  [DATA_W-1:0] byte to transmit
//   in_valid    input               producer has a byte
//   in_ready    output              can accept (IDLE only, decoded)
//   tx_serial   output              serial line, idle high (registered)
//   parity_out  output              parity of last accepted byte (registered)
//   busy        output              frame in progress (registered)
//   tx_done     output              pulse in final cycle of last stop bit
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | line high, waiting for in_valid
// ST_START  | driving start bit for CLKS_PER_BIT clocks
// ST_DATA   | driving data bit bit_cnt, LSB first
// ST_PARITY | driving the latched parity bit
// ST_STOP   | driving stop bit(s), bit_cnt counts stop bits
module even_parity_tx
  import even_parity_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_serial,
  output logic              parity_out,
  output logic              busy,
  output logic              tx_done
);

  localparam int CNT_W   = cnt_width(CLKS_PER_BIT);
  // The bit counter is reused for stop bits, so size it for the larger count.
  localparam int BIT_MAX = (DATA_W > STOP_BITS) ? DATA_W : STOP_BITS;
  localparam int BIT_W   = cnt_width(BIT_MAX);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  tx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  clk_cnt_q, clk_cnt_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              parity_q, parity_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              gen_parity;
  logic              cnt_wrap;
  logic              accept;

  even_parity_gen #(
    .DATA_W (DATA_W)
  ) u_parity_gen (
    .data_i   (in_data),
    .parity_o (gen_parity)
  );

  assign in_ready = (state_q == ST_IDLE);
  assign accept   = in_ready && in_valid;
  assign cnt_wrap = (clk_cnt_q == CNT_LAST);

  // Next-state and datapath.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;

    if (state_q != ST_IDLE) begin
      clk_cnt_d = cnt_wrap ? '0 : clk_cnt_q + CNT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        if (accept) begin
          state_d  = ST_START;
          shift_d  = in_data;
          parity_d = gen_parity;
        end
      end
      ST_START: begin
        if (cnt_wrap) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (cnt_wrap) begin
          if (bit_cnt_q == DATA_LAST) begin
            state_d   = ST_PARITY;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            shift_d   = shift_q >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (cnt_wrap) begin
          state_d   = ST_STOP;
          bit_cnt_d = '0;
        end
      end
      ST_STOP: begin
        if (cnt_wrap) begin
          if (bit_cnt_q == STOP_LAST) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        clk_cnt_d = '0;
        bit_cnt_d = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered line shows
  // the start bit in the first cycle after the accepting edge.
  always_comb begin
    tx_d = LINE_IDLE;
    case (state_d)
      ST_IDLE:   tx_d = LINE_IDLE;
      ST_START:  tx_d = START_BIT;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = parity_d;
      ST_STOP:   tx_d = LINE_IDLE;
      default:   tx_d = LINE_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_STOP) && (clk_cnt_d == CNT_LAST) &&
             (bit_cnt_d == STOP_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tx_q      <= LINE_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign tx_serial  = tx_q;
  assign parity_out = parity_q;
  assign busy       = busy_q;
  assign tx_done    = done_q;

endmodule

// File: tb/tb_even_parity_tx.sv
// Bench for even_parity_tx: instance a uses the default timing
// (CLKS_PER_BIT=4, STOP_BITS=1), instance b uses CLKS_PER_BIT=1, STOP_BITS=2.
// A frame-level model per instance predicts every output each cycle.
module tb_even_parity_tx;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n_a = 1'b1, rst_n_b = 1'b1;
  logic [7:0] in_data_a = '0, in_data_b = '0;
  logic       in_valid_a = 1'b0, in_valid_b = 1'b0;
  logic       in_ready_a, tx_a, par_a, busy_a, done_a;
  logic       in_ready_b, tx_b, par_b, busy_b, done_b;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  even_parity_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .in_data(in_data_a), .in_valid(in_valid_a),
    .in_ready(in_ready_a), .tx_serial(tx_a), .parity_out(par_a),
    .busy(busy_a), .tx_done(done_a)
  );

  even_parity_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .in_data(in_data_b), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .tx_serial(tx_b), .parity_out(par_b),
    .busy(busy_b), .tx_done(done_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line level for every clock of a frame, index 0 = first start-bit clock.
  function automatic logic [63:0] make_frame(input logic [7:0] d, input int cpb, input int stops);
    logic [63:0] f;
    logic v;
    int k;
    f = '1;
    k = 0;
    for (int b = 0; b < 10 + stops; b++) begin
      if (b == 0)      v = 1'b0;
      else if (b <= 8) v = d[b-1];
      else if (b == 9) v = ^d;
      else             v = 1'b1;
      for (int c = 0; c < cpb; c++) begin
        f[k] = v;
        k++;
      end
    end
    return f;
  endfunction

  // Frame model: a frame is accepted only after a full idle cycle.
  logic [63:0] fr_a = '0, fr_b = '0;
  int          len_a = 0, pos_a = 0, len_b = 0, pos_b = 0;
  logic        mpar_a = 1'b0, mpar_b = 1'b0;

  always @(posedge clk or negedge rst_n_a) begin
    if (!rst_n_a) begin
      len_a <= 0; pos_a <= 0; mpar_a <= 1'b0;
    end else if (pos_a < len_a) begin
      pos_a <= pos_a + 1;
    end else if (in_valid_a) begin
      fr_a   <= make_frame(in_data_a, 4, 1);
      len_a  <= (2 + 8 + 1) * 4;
      pos_a  <= 0;
      mpar_a <= ^in_data_a;
    end
  end

  always @(posedge clk or negedge rst_n_b) begin
    if (!rst_n_b) begin
      len_b <= 0; pos_b <= 0; mpar_b <= 1'b0;
    end else if (pos_b < len_b) begin
      pos_b <= pos_b + 1;
    end else if (in_valid_b) begin
      fr_b   <= make_frame(in_data_b, 1, 2);
      len_b  <= (2 + 8 + 2) * 1;
      pos_b  <= 0;
      mpar_b <= ^in_data_b;
    end
  end

  task automatic cmp_dut(input string tag, input logic tx, input logic rdy, input logic bsy,
                         input logic par, input logic dn, input logic [63:0] fr,
                         input int len, input int pos, input logic mpar);
    logic b_e;
    b_e = (pos < len);
    check({tag, "_tx_serial"},  tx,  b_e ? fr[pos] : 1'b1);
    check({tag, "_in_ready"},   rdy, !b_e);
    check({tag, "_busy"},       bsy, b_e);
    check({tag, "_tx_done"},    dn,  b_e && (pos == len - 1));
    check({tag, "_parity_out"}, par, mpar);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_dut("a", tx_a, in_ready_a, busy_a, par_a, done_a, fr_a, len_a, pos_a, mpar_a);
      cmp_dut("b", tx_b, in_ready_b, busy_b, par_b, done_b, fr_b, len_b, pos_b, mpar_b);
    end
  end

  function automatic logic get_tx(input bit sel);   return sel ? tx_b : tx_a;             endfunction
  function automatic logic get_rdy(input bit sel);  return sel ? in_ready_b : in_ready_a; endfunction
  function automatic logic get_busy(input bit sel); return sel ? busy_b : busy_a;         endfunction
  function automatic logic get_par(input bit sel);  return sel ? par_b : par_a;           endfunction
  function automatic logic get_done(input bit sel); return sel ? done_b : done_a;         endfunction

  task automatic drive(input bit sel, input logic v, input logic [7:0] d);
    if (sel) begin in_valid_b = v; in_data_b = d; end
    else     begin in_valid_a = v; in_data_a = d; end
  endtask

  task automatic wait_ready(input bit sel);
    for (int i = 0; i < 200 && !get_rdy(sel); i++) begin
      @(posedge clk); #1;
    end
    check("ready_timeout", get_rdy(sel), 1'b1);
  endtask

  // Sends one byte and checks each clock of the line against a literal
  // bit sequence (seq[i] = i-th serial bit), plus tx_done timing and parity.
  task automatic run_frame(input bit sel, input logic [7:0] d, input int cpb, input int nbits,
                           input logic [15:0] seq, input logic exp_par);
    int done_at;
    int flen;
    flen = cpb * nbits;
    done_at = 0;
    wait_ready(sel);
    drive(sel, 1'b1, d);
    @(posedge clk); #1;
    drive(sel, 1'b0, ~d);
    for (int c = 0; c < flen; c++) begin
      check("line_seq", get_tx(sel), seq[c / cpb]);
      check("busy_in_frame", get_busy(sel), 1'b1);
      if (get_done(sel) && done_at == 0) done_at = c + 1;
      @(posedge clk); #1;
    end
    check("done_cycle", done_at, flen);
    check("parity_out", get_par(sel), exp_par);
    check("ready_after", get_rdy(sel), 1'b1);
  endtask

  initial begin
    logic [63:0] f;

    #2;
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    chk_en  = 1'b1;
    #1;
    check("rst_tx_a", tx_a, 1'b1);
    check("rst_ready_a", in_ready_a, 1'b1);
    check("rst_busy_a", busy_a, 1'b0);
    check("rst_par_a", par_a, 1'b0);
    check("rst_done_a", done_a, 1'b0);
    check("rst_tx_b", tx_b, 1'b1);
    @(negedge clk);
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;

    f = make_frame(8'h3C, 4, 1);
    check("model_3c_d2", f[12], 1'b1);
    check("model_3c_par", f[39:36], 4'h0);
    f = make_frame(8'h80, 1, 2);
    check("model_80_frame", f[11:0], 12'hF00);

    repeat (20) begin
      @(posedge clk); #1;
      check("idle_tx", tx_a, 1'b1);
      check("idle_ready", in_ready_a, 1'b1);
      check("idle_busy", busy_a, 1'b0);
    end

    run_frame(1'b0, 8'h3C, 4, 11, 16'b10001111000, 1'b0);
    run_frame(1'b0, 8'h1C, 4, 11, 16'b11000111000, 1'b1);
    run_frame(1'b0, 8'hFF, 4, 11, 16'b10111111110, 1'b0);
    run_frame(1'b0, 8'h01, 4, 11, 16'b11000000010, 1'b1);

    // Back-to-back with in_valid held high; data changes during frame 1.
    wait_ready(1'b0);
    drive(1'b0, 1'b1, 8'hA5);
    @(posedge clk); #1;
    in_data_a = 8'h3C;
    repeat (43) begin @(posedge clk); #1; end
    check("b2b_done_44", done_a, 1'b1);
    check("b2b_par_a5", par_a, 1'b0);
    @(posedge clk); #1;
    check("b2b_gap_line", tx_a, 1'b1);
    check("b2b_gap_ready", in_ready_a, 1'b1);
    @(posedge clk); #1;
    check("b2b_start", tx_a, 1'b0);
    check("b2b_busy", busy_a, 1'b1);
    drive(1'b0, 1'b0, 8'h00);
    wait_ready(1'b0);
    check("b2b_par_3c", par_a, 1'b0);

    // Asynchronous reset in the middle of DATA.
    drive(1'b0, 1'b1, 8'h55);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 8'h00);
    repeat (9) @(posedge clk);
    #1;
    check("pre_rst_line", tx_a, 1'b0);
    check("pre_rst_par", par_a, 1'b0);
    #2;
    rst_n_a = 1'b0;
    #1;
    check("rst_mid_tx", tx_a, 1'b1);
    check("rst_mid_busy", busy_a, 1'b0);
    check("rst_mid_ready", in_ready_a, 1'b1);
    @(negedge clk);
    rst_n_a = 1'b1;
    run_frame(1'b0, 8'h0F, 4, 11, 16'b10000011110, 1'b0);

    // One clock per bit, two stop bits.
    run_frame(1'b1, 8'h80, 1, 12, 16'b111100000000, 1'b1);

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
